regfile_dump: RTL
=================

Name: regfile_dump

Overview:
- Debug reader for the CPU register file: on a start pulse, walks registers 0..NUM_REGS-1 through one spare asynchronous read port.
- Serializes each register as a 5-byte frame onto a valid/ready byte stream; the downstream consumer is a UART TX or host bridge.
- Sits beside the register file, on the opposite end of the write path, and never writes the file.
- Each word is snapshotted before serialization, so CPU writes during a frame cannot tear it.

Parameters:
- NUM_REGS, 32, number of registers dumped (1..32), starting at address 0.
- ADDR_W, 5, width of rf_addr.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a dump; ignored while busy.
- rf_addr  out  ADDR_W  read address to the register-file read port.
- rf_data  in  32  combinational read data for rf_addr.
- tx_data  out  8  stream byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  consumer accepts the byte this cycle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final byte handshake.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, idx 0, byte_cnt 0, snapshot 0.
- State IDLE:
  - busy=0, tx_valid=0, rf_addr=0.
  - start=1 at a rising edge -> LOAD with idx=0.
- State LOAD (exactly 1 cycle):
  - rf_addr=idx.
  - At the closing edge, snapshot<=rf_data, byte_cnt<=0, -> SEND.
- State SEND:
  - tx_valid=1. tx_data by byte_cnt: 0 = {3'b0, idx}; 1 = snapshot[31:24]; 2 = [23:16]; 3 = [15:8]; 4 = [7:0].
  - Handshake occurs when tx_valid && tx_ready at a rising edge; byte_cnt advances only on handshake.
  - Handshake with byte_cnt==4:
    - idx==NUM_REGS-1 -> DONE.
    - Otherwise idx<=idx+1 -> LOAD.
- State DONE (1 cycle): done=1, busy=0, tx_valid=0, then -> IDLE. done is registered.
- busy=1 in LOAD and SEND.
- Stream rules:
  - Once tx_valid rises, tx_data stays stable and tx_valid stays high until handshake.
  - tx_valid never depends combinationally on tx_ready.
  - No bubble between bytes of a frame when tx_ready stays high.
- rf_addr holds idx throughout LOAD and SEND, i.e. it is not driven back to 0 between frames.
- Latency and throughput:
  - start sampled at edge E0 -> LOAD in cycle 1 -> first tx_valid in cycle 2.
  - With tx_ready=1 constantly: 6 cycles per register.
  - NUM_REGS=32 -> last handshake at edge 192, done high in cycle 193, back in IDLE at cycle 194.
- Boundaries:
  - start while busy or in DONE: ignored, with no queuing.
  - start in IDLE the cycle after DONE: accepted.
  - rf_data changes during SEND (CPU write to the same register): the frame carries the LOAD-cycle value; the next register reads fresh data.
  - NUM_REGS=1: a single 5-byte frame, then DONE.
  - idx wrap is impossible; idx is compared against NUM_REGS-1, never incremented past it.
  - tx_ready held low indefinitely: block stalls in SEND with outputs stable, no timeout.
  - rst_n asserted mid-dump: immediate return to IDLE with all outputs 0, no done pulse. After release, a new start restarts from register 0.
- Width rules: the header byte zero-extends idx to 8 bits. Data bytes go out MSB first.

Test Plan:
- Full dump, tx_ready=1: load regs with 32'h1000_0000+i, pulse start -> 160 bytes, frame i = {i, 8'h10, 8'h00, 8'h00, i}; done exactly in cycle 193 after start; busy high in cycles 1..192.
- Backpressure: tx_ready toggles 1,0,0 repeating -> tx_data/tx_valid constant during every stall, byte sequence identical to the ready=1 case, done after the last accepted byte.
- Snapshot integrity: reg 3 = 32'hDEAD_BEEF; overwrite to 32'h0 during its second data byte -> frame 3 reads 03 DE AD BE EF.
- start pulses at cycles 5 and 100 of an ongoing dump, and during DONE -> ignored, single done pulse, 160 bytes total; start one cycle after DONE -> a second full dump.
- Reset at cycle 50 mid-frame -> tx_valid, busy, done, rf_addr all 0 asynchronously; after release, start -> first byte 8'h00 (header of reg 0).
- NUM_REGS=1, reg 0 = 0 -> bytes 00 00 00 00 00, done in cycle 7 with tx_ready=1.

Source files
------------

// File: rtl/regfile_dump_if.sv
// Bus bundle for the register-file dump reader: the spare asynchronous
// read port of the register file plus the outgoing valid/ready byte stream.
`timescale 1ns/1ps
interface regfile_dump_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rf_addr;
  logic [31:0]       rf_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  // The dump reader drives the read address and the stream.
  modport master (
    output rf_addr, tx_data, tx_valid,
    input  rf_data, tx_ready
  );

  // The register file and the byte consumer sit on this side.
  modport slave (
    input  rf_addr, tx_data, tx_valid,
    output rf_data, tx_ready
  );
endinterface

// File: rtl/regfile_dump.sv
// Register-file dump reader. On a start pulse it walks registers
// 0..NUM_REGS-1 through a read-only port, snapshots each word and emits it
// as a 5-byte frame: {idx, data[31:24], data[23:16], data[15:8], data[7:0]}.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// LOAD  | one cycle, rf_addr=idx, word captured into snapshot
// SEND  | presenting frame bytes, advances on each handshake
// DONE  | one cycle, done pulse
`timescale 1ns/1ps
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  regfile_dump_if.master bus,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [2:0]        byte_cnt, byte_cnt_nxt;
  logic [31:0]       snapshot, snapshot_nxt;
  logic              done_nxt;

  // State and datapath registers; done is a flop so it is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      byte_cnt <= 3'd0;
      snapshot <= 32'h0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      byte_cnt <= byte_cnt_nxt;
      snapshot <= snapshot_nxt;
      done     <= done_nxt;
    end
  end

  // Next-state and outputs; tx_valid decodes from state only, never tx_ready.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    byte_cnt_nxt = byte_cnt;
    snapshot_nxt = snapshot;
    done_nxt     = 1'b0;
    busy         = 1'b0;
    bus.rf_addr  = '0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    case (state)
      IDLE: begin
        if (start) begin
          idx_nxt   = '0;
          state_nxt = LOAD;
        end
      end

      LOAD: begin
        busy         = 1'b1;
        bus.rf_addr  = idx;
        snapshot_nxt = bus.rf_data;
        byte_cnt_nxt = 3'd0;
        state_nxt    = SEND;
      end

      SEND: begin
        busy         = 1'b1;
        bus.rf_addr  = idx;
        bus.tx_valid = 1'b1;
        case (byte_cnt)
          3'd0:    bus.tx_data = 8'(idx);
          3'd1:    bus.tx_data = snapshot[31:24];
          3'd2:    bus.tx_data = snapshot[23:16];
          3'd3:    bus.tx_data = snapshot[15:8];
          default: bus.tx_data = snapshot[7:0];
        endcase
        if (bus.tx_ready) begin
          if (byte_cnt == 3'd4) begin
            if (idx == LAST_IDX) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else begin
              idx_nxt   = idx + 1'b1;
              state_nxt = LOAD;
            end
          end else begin
            byte_cnt_nxt = byte_cnt + 3'd1;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
